// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port between REQS requesters using round-robin grants.
// A grant is held until the RAM returns ACCESS or the owner drops its request.
// Optional build macro RAM_ARB_PERF_EN adds xfer_count / stall_count performance counters.
module ram_arbiter #(
    parameter int unsigned REQS   = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    localparam int unsigned IDW   = $clog2(REQS)
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [REQS-1:0]          req_ren,
    input  logic [REQS-1:0]          req_wen,
    input  logic [REQS*ADDR_W-1:0]   req_addr,
    input  logic [REQS*DATA_W-1:0]   req_store,
    output logic [REQS-1:0]          req_wait,
    output logic [DATA_W-1:0]        req_load,
    output logic [ADDR_W-1:0]        ramaddr,
    output logic [DATA_W-1:0]        ramstore,
    output logic                     ramREN,
    output logic                     ramWEN,
    input  logic [DATA_W-1:0]        ramload,
    input  logic [1:0]               ramstate,
`ifdef RAM_ARB_PERF_EN
    output logic [31:0]              xfer_count,
    output logic [31:0]              stall_count,
`endif
    output logic [IDW-1:0]           grant_id,
    output logic                     grant_valid
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [0:0] {IDLE, OWN} state_t;

    state_t           state_q;
    logic [IDW-1:0]   rr_ptr_q;
    logic [IDW-1:0]   owner_q;

    logic [REQS-1:0]  active;
    logic [REQS-1:0]  done_mask;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   cand;
    logic             found;
    logic             own;
    logic             done;

    assign active   = req_ren | req_wen;
    assign own      = (state_q == OWN);
    // Completion needs the owner still asking; a withdrawn request is an abort, not a completion.
    assign done     = own && (ramstate == RAM_ACCESS) && active[owner_q];
    assign grant_id = owner_q;

    // Round-robin search: first active index at or above rr_ptr, wrapping.
    always_comb begin
        winner = rr_ptr_q;
        cand   = '0;
        found  = 1'b0;
        for (int k = 0; k < int'(REQS); k++) begin
            cand = rr_ptr_q + IDW'(k);
            if (!found && active[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Requester-side outputs: only the completing owner is released, and only for one cycle.
    always_comb begin
        done_mask = '0;
        if (done) begin
            done_mask[owner_q] = 1'b1;
        end
        req_wait = active & ~done_mask;
        req_load = done ? ramload : '0;
    end

    // RAM-side outputs follow the owner's request combinationally; write wins over read.
    always_comb begin
        ramaddr  = '0;
        ramstore = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        if (own) begin
            ramaddr  = req_addr[owner_q*ADDR_W +: ADDR_W];
            ramstore = req_store[owner_q*DATA_W +: DATA_W];
            ramWEN   = req_wen[owner_q];
            ramREN   = req_ren[owner_q] & ~req_wen[owner_q];
        end
    end

    // Grant FSM: IDLE picks a winner, OWN holds until completion or abort.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            grant_valid <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        owner_q     <= winner;
                        grant_valid <= 1'b1;
                        state_q     <= OWN;
                    end
                end
                OWN: begin
                    // FREE, BUSY and ERROR all hold the grant; the RAM retries on ERROR.
                    if (!active[owner_q] || ramstate == RAM_ACCESS) begin
                        rr_ptr_q    <= owner_q + IDW'(1);
                        grant_valid <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef RAM_ARB_PERF_EN
    // Performance counters: completed transfers and cycles with any requester stalled.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            xfer_count  <= '0;
            stall_count <= '0;
        end else begin
            if (done) begin
                xfer_count <= xfer_count + 32'd1;
            end
            if (|req_wait) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed stimulus for ram_arbiter, checked every cycle against a
// behavioural model of the arbitration rules plus literal pins for the key scenarios.
module tb_ram_arbiter;

    localparam int REQS   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int IDW    = 2;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic                   CLK = 1'b0;
    logic                   nRST;
    logic [REQS-1:0]        req_ren;
    logic [REQS-1:0]        req_wen;
    logic [REQS*ADDR_W-1:0] req_addr;
    logic [REQS*DATA_W-1:0] req_store;
    logic [REQS-1:0]        req_wait;
    logic [DATA_W-1:0]      req_load;
    logic [ADDR_W-1:0]      ramaddr;
    logic [DATA_W-1:0]      ramstore;
    logic                   ramREN;
    logic                   ramWEN;
    logic [DATA_W-1:0]      ramload;
    logic [1:0]             ramstate;
    logic [IDW-1:0]         grant_id;
    logic                   grant_valid;
`ifdef RAM_ARB_PERF_EN
    logic [31:0]            xfer_count;
    logic [31:0]            stall_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    ram_arbiter #(
        .REQS   (REQS),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .req_ren     (req_ren),
        .req_wen     (req_wen),
        .req_addr    (req_addr),
        .req_store   (req_store),
        .req_wait    (req_wait),
        .req_load    (req_load),
        .ramaddr     (ramaddr),
        .ramstore    (ramstore),
        .ramREN      (ramREN),
        .ramWEN      (ramWEN),
        .ramload     (ramload),
        .ramstate    (ramstate),
`ifdef RAM_ARB_PERF_EN
        .xfer_count  (xfer_count),
        .stall_count (stall_count),
`endif
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Model state: whether a grant is held, by whom, and where the next search starts.
    bit              m_own   = 1'b0;
    int              m_owner = 0;
    int              m_ptr   = 0;
    logic [31:0]     m_xfer  = '0;
    logic [31:0]     m_stall = '0;
    logic [REQS-1:0] m_act;
    logic [REQS-1:0] e_wait;
    logic            m_done;
    logic            e_wen;
    logic            e_ren;
    int              k;

    // Compare process: outputs checked on every falling edge, then the model advances.
    always @(negedge CLK) begin
        m_act = req_ren | req_wen;
        if (!nRST) begin
            m_own   = 1'b0;
            m_owner = 0;
            m_ptr   = 0;
            m_xfer  = '0;
            m_stall = '0;
            chk("rst_ramREN", 64'(ramREN), 64'd0);
            chk("rst_ramWEN", 64'(ramWEN), 64'd0);
            chk("rst_ramaddr", 64'(ramaddr), 64'd0);
            chk("rst_ramstore", 64'(ramstore), 64'd0);
            chk("rst_grant_valid", 64'(grant_valid), 64'd0);
            chk("rst_grant_id", 64'(grant_id), 64'd0);
            chk("rst_req_wait", 64'(req_wait), 64'(m_act));
            chk("rst_req_load", 64'(req_load), 64'd0);
`ifdef RAM_ARB_PERF_EN
            chk("rst_xfer_count", 64'(xfer_count), 64'd0);
            chk("rst_stall_count", 64'(stall_count), 64'd0);
`endif
        end else begin
            m_done = m_own && (ramstate == ACCESS) && m_act[m_owner];
            e_wait = m_act;
            if (m_done) e_wait[m_owner] = 1'b0;
            e_wen = m_own && req_wen[m_owner];
            e_ren = m_own && req_ren[m_owner] && !req_wen[m_owner];
            chk("ramREN", 64'(ramREN), 64'(e_ren));
            chk("ramWEN", 64'(ramWEN), 64'(e_wen));
            chk("ramaddr", 64'(ramaddr),
                m_own ? 64'(req_addr[m_owner*ADDR_W +: ADDR_W]) : 64'd0);
            chk("ramstore", 64'(ramstore),
                m_own ? 64'(req_store[m_owner*DATA_W +: DATA_W]) : 64'd0);
            chk("req_wait", 64'(req_wait), 64'(e_wait));
            chk("req_load", 64'(req_load), m_done ? 64'(ramload) : 64'd0);
            chk("grant_valid", 64'(grant_valid), 64'(m_own));
            if (m_own) chk("grant_id", 64'(grant_id), 64'(m_owner));
`ifdef RAM_ARB_PERF_EN
            chk("xfer_count", 64'(xfer_count), 64'(m_xfer));
            chk("stall_count", 64'(stall_count), 64'(m_stall));
            if (m_done) m_xfer = m_xfer + 32'd1;
            if (e_wait != '0) m_stall = m_stall + 32'd1;
`endif
            if (!m_own) begin
                for (int j = REQS - 1; j >= 0; j--) begin
                    k = (m_ptr + j) % REQS;
                    if (m_act[k]) begin
                        m_owner = k;
                        m_own   = 1'b1;
                    end
                end
            end else if (!m_act[m_owner] || ramstate == ACCESS) begin
                m_ptr = (m_owner + 1) % REQS;
                m_own = 1'b0;
            end
        end
    end

    // Expected round-robin trace: grant id while owning, 4 for an IDLE cycle.
    int rr_exp [9] = '{0, 4, 1, 4, 2, 4, 3, 4, 0};

    initial begin
        nRST      = 1'b0;
        req_ren   = '0;
        req_wen   = '0;
        req_addr  = '0;
        req_store = '0;
        ramload   = '0;
        ramstate  = FREE;

        // Reset with every requester asking.
        req_ren = 4'b1111;
        @(negedge CLK);
        chk("pin_rst_ren", 64'(ramREN), 64'd0);
        chk("pin_rst_wait", 64'(req_wait), 64'hF);
        chk("pin_rst_gv", 64'(grant_valid), 64'd0);
        tick();
        nRST = 1'b1;
        tick();
        @(negedge CLK);
        chk("pin_first_gv", 64'(grant_valid), 64'd1);
        chk("pin_first_gid", 64'(grant_id), 64'd0);
        tick();
        req_ren = '0;
        tick();
        tick();

        // Single read from requester 2 with three BUSY cycles.
        req_ren = 4'b0100;
        req_addr[2*ADDR_W +: ADDR_W] = 32'h40;
        ramstate = BUSY;
        tick();
        @(negedge CLK);
        chk("pin_rd_gid", 64'(grant_id), 64'd2);
        chk("pin_rd_wait", 64'(req_wait), 64'h4);
        tick();
        tick();
        tick();
        ramstate = ACCESS;
        ramload  = 32'hDEADBEEF;
        @(negedge CLK);
        chk("pin_rd_done_wait", 64'(req_wait), 64'h0);
        chk("pin_rd_load", 64'(req_load), 64'hDEADBEEF);
        chk("pin_rd_addr", 64'(ramaddr), 64'h40);
        tick();
        ramstate = FREE;
        ramload  = '0;
        @(negedge CLK);
        chk("pin_rd_idle_gv", 64'(grant_valid), 64'd0);
        chk("pin_rd_idle_wait", 64'(req_wait), 64'h4);
        chk("pin_rd_idle_load", 64'(req_load), 64'd0);

        // Re-granted to 2; async reset mid-grant must drop the RAM strobes at once.
        tick();
        chk("pin_pre_rst_ren", 64'(ramREN), 64'd1);
        nRST = 1'b0;
        #1;
        chk("pin_async_ren", 64'(ramREN), 64'd0);
        chk("pin_async_gv", 64'(grant_valid), 64'd0);
        req_ren = '0;

        // Round-robin with all requesters active and immediate ACCESS.
        tick();
        nRST     = 1'b1;
        req_ren  = 4'b1111;
        ramstate = ACCESS;
        ramload  = 32'h11;
        @(negedge CLK);
        chk("pin_rr_idle0", 64'(grant_valid), 64'd0);
        for (int i = 0; i < 9; i++) begin
            @(negedge CLK);
            chk("pin_rr_order", grant_valid ? 64'(grant_id) : 64'd4, 64'(rr_exp[i]));
        end
        tick();
        req_ren  = '0;
        ramstate = FREE;
        tick();

        // Write priority: requester 1 asserts both ren and wen.
        req_ren = 4'b0010;
        req_wen = 4'b0010;
        req_addr[1*ADDR_W +: ADDR_W]  = 32'h80;
        req_store[1*DATA_W +: DATA_W] = 32'h12345678;
        ramstate = BUSY;
        tick();
        @(negedge CLK);
        chk("pin_wr_wen", 64'(ramWEN), 64'd1);
        chk("pin_wr_ren", 64'(ramREN), 64'd0);
        chk("pin_wr_addr", 64'(ramaddr), 64'h80);
        chk("pin_wr_store", 64'(ramstore), 64'h12345678);
        chk("pin_wr_gid", 64'(grant_id), 64'd1);
        tick();
        ramstate = ACCESS;
        tick();
        req_ren  = '0;
        req_wen  = '0;
        ramstate = FREE;

        // Abort: owner 3 withdraws during BUSY; next search must start at 0, not 3.
        req_ren  = 4'b1000;
        ramstate = BUSY;
        tick();
        @(negedge CLK);
        chk("pin_ab_gid", 64'(grant_id), 64'd3);
        tick();
        req_ren = 4'b0000;
        @(negedge CLK);
        chk("pin_ab_wait", 64'(req_wait), 64'd0);
        chk("pin_ab_load", 64'(req_load), 64'd0);
        tick();
        req_ren = 4'b1001;
        tick();
        @(negedge CLK);
        chk("pin_ab_next_gid", 64'(grant_id), 64'd0);

        // ERROR for two cycles, then ACCESS: exactly one completion, after the ACCESS.
        ramstate = ERROR;
        ramload  = 32'hCAFE0001;
        @(negedge CLK);
        chk("pin_err1_wait", 64'(req_wait), 64'h9);
        chk("pin_err1_load", 64'(req_load), 64'd0);
        tick();
        @(negedge CLK);
        chk("pin_err2_wait", 64'(req_wait), 64'h9);
        tick();
        ramstate = ACCESS;
        @(negedge CLK);
        chk("pin_err_done_wait", 64'(req_wait), 64'h8);
        chk("pin_err_done_load", 64'(req_load), 64'hCAFE0001);
        tick();
        req_ren  = '0;
        ramstate = FREE;
        ramload  = '0;
        tick();
        tick();
        @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single cpu_ram_if RAM port between REQS requesters: the per-thread icache/dcache request streams of the SIMT core.
- Sits between the cache level and the RAM. It presents the RAM-side signals ramaddr, ramstore, ramREN and ramWEN, and consumes ramload and ramstate.
- Grants are round-robin. A grant is held until the RAM returns ACCESS or the owner withdraws its request.

Parameters:
- REQS, 4: number of requesters (≥2, power of two).
- ADDR_W, 32: address width.
- DATA_W, 32: data word width.
- IDW, $clog2(REQS): grant index width (derived, not overridden).

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- req_ren  in  REQS  per-requester read request.
- req_wen  in  REQS  per-requester write request.
- req_addr  in  REQS*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_store  in  REQS*DATA_W  packed write data, same packing as req_addr.
- req_wait  out  REQS  per-requester stall.
- req_load  out  DATA_W  read data, broadcast to all requesters.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramload  in  DATA_W  RAM read data.
- ramstate  in  2  RAM state: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
- grant_id  out  IDW  current owner index; valid only while grant_valid=1.
- grant_valid  out  1  high while in the OWN state.

Behaviour:
- Reset (async, nRST=0): state=IDLE, rr_ptr=0, owner=0. All outputs are 0: ramREN, ramWEN, ramaddr, ramstore, grant_valid, grant_id. req_wait equals the active-request mask.
- active[i] = req_ren[i] | req_wen[i].
- IDLE state:
  - RAM outputs are all 0.
  - If any active[i] is set, the winner is the first active index found by searching upward from rr_ptr, wrapping modulo REQS.
  - At the next edge: owner ← winner, state ← OWN.
  - With no active requester, stay in IDLE.
- OWN state:
  - ramaddr and ramstore are taken combinationally from the owner's slices.
  - If req_wen[owner]=1: ramWEN=1 and ramREN=0 (write wins when both are set). Otherwise ramREN=req_ren[owner].
- Completion: in OWN, with ramstate==ACCESS and active[owner]=1:
  - req_wait[owner]=0 for that cycle only.
  - req_load=ramload.
  - At the edge: rr_ptr ← owner+1 (mod REQS), state ← IDLE.
- Abort: in OWN, if active[owner]=0, go to IDLE at the next edge. rr_ptr ← owner+1 and no completion is signalled.
- Other ramstate values in OWN:
  - FREE and BUSY: hold OWN.
  - ERROR: hold OWN and keep requesting; the RAM retries. The arbiter issues no completion on ERROR.
- req_wait[i] = active[i] AND NOT completion-for-i. Inactive requesters see req_wait=0.
- req_load is 0 except in a completion cycle.
- Arbitration overhead: one IDLE cycle between consecutive grants. Minimum transaction time is 2 cycles (IDLE + one OWN cycle with ACCESS).
- Fairness: with all REQS requesters continuously active, grants go rr_ptr, rr_ptr+1, … in order. No requester waits more than REQS-1 transactions.
- Requester inputs change only at edges.
- Address/data changes by the owner mid-grant pass straight through; keeping them stable is the requester's responsibility.
- Reset asserted mid-grant: ramREN and ramWEN drop immediately (async). The in-flight transaction is abandoned.

Optional Feature:
- Macro: RAM_ARB_PERF_EN.
- When defined, adds the following ports and logic:
  - Output xfer_count (32-bit): increments on each completion.
  - Output stall_count (32-bit): increments each cycle in which any req_wait bit is 1.
  - Both counters reset to 0 on nRST and wrap at 2^32.
- When undefined: neither port nor the counter logic exists; all other behaviour is identical.

Test Plan:
- Reset check: hold nRST=0 with req_ren=4'b1111 → ramREN=0, ramWEN=0, grant_valid=0, req_wait=4'b1111. Release → first grant goes to index 0.
- Single read: req_ren[2]=1, addr 0x40; RAM returns ACCESS after 3 BUSY cycles with ramload=0xDEADBEEF → grant_id=2. req_wait[2] falls for exactly one cycle, with req_load=0xDEADBEEF in that cycle. Next cycle returns to IDLE.
- Round-robin: all four requesters active continuously, RAM gives ACCESS on the first OWN cycle → grant order 0,1,2,3,0,… with exactly one IDLE cycle between grants.
- Write priority: requester 1 sets ren=wen=1, addr 0x80, store 0x12345678 → ramWEN=1, ramREN=0, ramaddr=0x80, ramstore=0x12345678.
- Abort and error:
  - Owner 3 drops its request while ramstate=BUSY → no completion; next grant search starts at index 0.
  - ramstate=ERROR for 2 cycles, then ACCESS → a single completion, after the ACCESS.
- Perf (RAM_ARB_PERF_EN): 4 completed transactions and 10 cycles with any wait high → xfer_count=4, stall_count=10. Async reset clears both to 0.
